// File: rtl/mem_arbiter.sv
// Arbitrates the pipeline's instruction and data interfaces onto one shared
// dual-port memory (one read port, one write port, 1-cycle registered read).
module mem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int DATA_BASE = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] inst_data,
    input  logic [WIDTH-1:0] inst_rdaddress,
    input  logic [WIDTH-1:0] inst_wraddress,
    input  logic             inst_rden,
    input  logic             inst_wren,
    output logic [WIDTH-1:0] inst_q,
    output logic             inst_valid,
    output logic             inst_stall,
    input  logic [WIDTH-1:0] data_data,
    input  logic [WIDTH-1:0] data_rdaddress,
    input  logic [WIDTH-1:0] data_wraddress,
    input  logic             data_rden,
    input  logic             data_wren,
    output logic [WIDTH-1:0] data_q,
    output logic             data_valid,
    output logic             data_stall,
    output logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] mem_rdaddress,
    output logic [WIDTH-1:0] mem_wraddress,
    output logic             mem_rden,
    output logic             mem_wren,
    input  logic [WIDTH-1:0] mem_q,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    logic             last_win_q, last_win_d;
    owner_e           rd_owner_q, rd_owner_d;
    logic [WIDTH-1:0] inst_hold_q, inst_hold_d;
    logic [WIDTH-1:0] data_hold_q, data_hold_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic inst_act, data_act, conflict, inst_gnt, data_gnt;

    always_comb begin
        inst_act = inst_rden | inst_wren;
        data_act = data_rden | data_wren;
        conflict = inst_act & data_act &
                   ((inst_rden & data_rden) | (inst_wren & data_wren));
        // last_win_q names the previous conflict winner; the other port wins now.
        inst_gnt = ~reset & inst_act & ~(conflict & ~last_win_q);
        data_gnt = ~reset & data_act & ~(conflict & last_win_q);
        inst_stall = reset | (inst_act & ~inst_gnt);
        data_stall = reset | (data_act & ~data_gnt);
    end

    always_comb begin
        mem_rden      = 1'b0;
        mem_rdaddress = '0;
        mem_wren      = 1'b0;
        mem_wraddress = '0;
        mem_data      = '0;
        rd_owner_d    = OWN_NONE;
        if (inst_gnt && inst_rden) begin
            mem_rden      = 1'b1;
            mem_rdaddress = inst_rdaddress;
            rd_owner_d    = OWN_INST;
        end else if (data_gnt && data_rden) begin
            mem_rden      = 1'b1;
            mem_rdaddress = data_rdaddress + WIDTH'(DATA_BASE);
            rd_owner_d    = OWN_DATA;
        end
        if (inst_gnt && inst_wren) begin
            mem_wren      = 1'b1;
            mem_wraddress = inst_wraddress;
            mem_data      = inst_data;
        end else if (data_gnt && data_wren) begin
            mem_wren      = 1'b1;
            mem_wraddress = data_wraddress + WIDTH'(DATA_BASE);
            mem_data      = data_data;
        end
    end

    always_comb begin
        last_win_d     = conflict ? ~last_win_q : last_win_q;
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
        inst_valid  = ~reset & (rd_owner_q == OWN_INST);
        data_valid  = ~reset & (rd_owner_q == OWN_DATA);
        // Returned word passes straight through and is also kept for later cycles.
        inst_hold_d = inst_valid ? mem_q : inst_hold_q;
        data_hold_d = data_valid ? mem_q : data_hold_q;
        inst_q      = reset ? '0 : inst_hold_d;
        data_q      = reset ? '0 : data_hold_d;
        conflict_cnt = conflict_cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_win_q     <= 1'b0;
            rd_owner_q     <= OWN_NONE;
            inst_hold_q    <= '0;
            data_hold_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            last_win_q     <= last_win_d;
            rd_owner_q     <= rd_owner_d;
            inst_hold_q    <= inst_hold_d;
            data_hold_q    <= data_hold_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter: a reference model predicts
// grants and read results, a monitor checks returned words from a queue.
module tb_mem_arbiter;
    localparam int W       = 32;
    localparam int BASE    = 64;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] inst_data, inst_rdaddress, inst_wraddress;
    logic         inst_rden, inst_wren;
    logic [W-1:0] inst_q;
    logic         inst_valid, inst_stall;
    logic [W-1:0] data_data, data_rdaddress, data_wraddress;
    logic         data_rden, data_wren;
    logic [W-1:0] data_q;
    logic         data_valid, data_stall;
    logic [W-1:0] mem_data, mem_rdaddress, mem_wraddress;
    logic         mem_rden, mem_wren;
    logic [W-1:0] mem_q = '0;
    logic [CW-1:0] conflict_cnt;

    mem_arbiter #(.WIDTH(W), .DATA_BASE(BASE), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .inst_data(inst_data), .inst_rdaddress(inst_rdaddress),
        .inst_wraddress(inst_wraddress), .inst_rden(inst_rden),
        .inst_wren(inst_wren), .inst_q(inst_q), .inst_valid(inst_valid),
        .inst_stall(inst_stall),
        .data_data(data_data), .data_rdaddress(data_rdaddress),
        .data_wraddress(data_wraddress), .data_rden(data_rden),
        .data_wren(data_wren), .data_q(data_q), .data_valid(data_valid),
        .data_stall(data_stall),
        .mem_data(mem_data), .mem_rdaddress(mem_rdaddress),
        .mem_wraddress(mem_wraddress), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_q(mem_q), .conflict_cnt(conflict_cnt)
    );

    // ---------------- clock / shared memory ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    function automatic logic [W-1:0] init_word(input int i);
        logic [W-1:0] v;
        v = (W'(i) * 32'h0101_0101) ^ 32'h5a5a_0000;
        if (i == 5)  v = 32'h0000_00A5;
        if (i == 70) v = 32'h0000_003C;
        return v;
    endfunction

    logic [W-1:0] env_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) env_mem[i] = init_word(i);
        forever begin
            @(posedge clock);
            if (mem_rden) mem_q <= env_mem[mem_rdaddress[7:0]];
            if (mem_wren) env_mem[mem_wraddress[7:0]] <= mem_data;
        end
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [W-1:0] inst_exp_q[$];
    int           inst_cyc_q[$];
    logic [W-1:0] data_exp_q[$];
    int           data_cyc_q[$];

    // Reference model: word-addressed memory, alternating conflict winner.
    logic [W-1:0] ref_mem [0:255];
    logic         data_turn;
    int           model_cnt;
    logic         last_ig, last_dg;

    task automatic model_reset();
        data_turn = 1'b1;
        model_cnt = 0;
        last_ig   = 1'b1;
        last_dg   = 1'b1;
        inst_exp_q.delete(); inst_cyc_q.delete();
        data_exp_q.delete(); data_cyc_q.delete();
    endtask

    task automatic model_step();
        logic i_act, d_act, confl, ig, dg, e_rden, e_wren;
        logic [W-1:0] d_rd, d_wr, e_rda, e_wra, e_wd;
        i_act = inst_rden || inst_wren;
        d_act = data_rden || data_wren;
        confl = i_act && d_act && ((inst_rden && data_rden) || (inst_wren && data_wren));
        ig = i_act && !(confl && data_turn);
        dg = d_act && !(confl && !data_turn);
        d_rd = data_rdaddress + BASE;
        d_wr = data_wraddress + BASE;
        e_rden = (ig && inst_rden) || (dg && data_rden);
        e_rda  = (ig && inst_rden) ? inst_rdaddress : ((dg && data_rden) ? d_rd : '0);
        e_wren = (ig && inst_wren) || (dg && data_wren);
        e_wra  = (ig && inst_wren) ? inst_wraddress : ((dg && data_wren) ? d_wr : '0);
        e_wd   = (ig && inst_wren) ? inst_data : ((dg && data_wren) ? data_data : '0);
        check("inst_stall", inst_stall, i_act && !ig);
        check("data_stall", data_stall, d_act && !dg);
        check("conflict_cnt", conflict_cnt, model_cnt);
        check("mem_rden", mem_rden, e_rden);
        check("mem_rdaddress", mem_rdaddress, e_rda);
        check("mem_wren", mem_wren, e_wren);
        check("mem_wraddress", mem_wraddress, e_wra);
        check("mem_data", mem_data, e_wd);
        if (ig && inst_rden) begin
            inst_exp_q.push_back(ref_mem[inst_rdaddress[7:0]]);
            inst_cyc_q.push_back(cyc);
        end
        if (dg && data_rden) begin
            data_exp_q.push_back(ref_mem[d_rd[7:0]]);
            data_cyc_q.push_back(cyc);
        end
        if (ig && inst_wren) ref_mem[inst_wraddress[7:0]] = inst_data;
        if (dg && data_wren) ref_mem[d_wr[7:0]] = data_data;
        if (confl) begin
            data_turn = !data_turn;
            if (model_cnt < CNT_MAX) model_cnt++;
        end
        last_ig = ig || !i_act;
        last_dg = dg || !d_act;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] last_i = '0;
    logic [W-1:0] last_d = '0;
    int n_inst_valid = 0;
    int n_data_valid = 0;

    always @(negedge clock) begin
        if (reset) begin
            last_i = '0;
            last_d = '0;
        end else begin
            if (inst_valid) begin
                n_inst_valid++;
                if (inst_exp_q.size() == 0) begin
                    check("inst_valid_unexpected", inst_valid, 1'b0);
                end else begin
                    check("inst_q", inst_q, inst_exp_q[0]);
                    check("inst_latency", cyc, inst_cyc_q[0] + 1);
                    last_i = inst_exp_q.pop_front();
                    void'(inst_cyc_q.pop_front());
                end
            end else begin
                check("inst_hold", inst_q, last_i);
                if (inst_cyc_q.size() > 0 && inst_cyc_q[0] < cyc) begin
                    check("inst_valid_missing", inst_valid, 1'b1);
                    void'(inst_exp_q.pop_front());
                    void'(inst_cyc_q.pop_front());
                end
            end
            if (data_valid) begin
                n_data_valid++;
                if (data_exp_q.size() == 0) begin
                    check("data_valid_unexpected", data_valid, 1'b0);
                end else begin
                    check("data_q", data_q, data_exp_q[0]);
                    check("data_latency", cyc, data_cyc_q[0] + 1);
                    last_d = data_exp_q.pop_front();
                    void'(data_cyc_q.pop_front());
                end
            end else begin
                check("data_hold", data_q, last_d);
                if (data_cyc_q.size() > 0 && data_cyc_q[0] < cyc) begin
                    check("data_valid_missing", data_valid, 1'b1);
                    void'(data_exp_q.pop_front());
                    void'(data_cyc_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        inst_rden = 1'b0; inst_wren = 1'b0;
        inst_rdaddress = '0; inst_wraddress = '0; inst_data = '0;
        data_rden = 1'b0; data_wren = 1'b0;
        data_rdaddress = '0; data_wraddress = '0; data_data = '0;
    endtask

    task automatic at_neg();
        @(negedge clock);
        model_step();
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_inst_stall"}, inst_stall, 1'b1);
        check({tag, "_data_stall"}, data_stall, 1'b1);
        check({tag, "_inst_valid"}, inst_valid, 1'b0);
        check({tag, "_inst_q"}, inst_q, '0);
        check({tag, "_mem_rden"}, mem_rden, 1'b0);
        check({tag, "_mem_wren"}, mem_wren, 1'b0);
        check({tag, "_cnt"}, conflict_cnt, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v_i, v_d, r;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        idle();
        model_reset();
        #2;
        @(negedge clock);
        check_in_reset("por");
        do_reset();

        // Simultaneous reads: data wins the first conflict.
        inst_rden = 1'b1; inst_rdaddress = 32'd5;
        data_rden = 1'b1; data_rdaddress = 32'd6;
        at_neg();
        check("t1_rdaddr_data", mem_rdaddress, 32'd70);
        check("t1_inst_stall", inst_stall, 1'b1);
        next_cycle();
        data_rden = 1'b0;
        at_neg();
        check("t1_cnt", conflict_cnt, 4'd1);
        check("t1_data_valid", data_valid, 1'b1);
        check("t1_data_q", data_q, 32'h3C);
        check("t1_rdaddr_inst", mem_rdaddress, 32'd5);
        next_cycle();
        idle();
        at_neg();
        check("t1_inst_valid", inst_valid, 1'b1);
        check("t1_inst_q", inst_q, 32'hA5);
        next_cycle();

        // Inst read in parallel with data write.
        inst_rden = 1'b1; inst_rdaddress = 32'd0;
        data_wren = 1'b1; data_wraddress = 32'd1; data_data = 32'hDEADBEEF;
        at_neg();
        check("t2_inst_stall", inst_stall, 1'b0);
        check("t2_data_stall", data_stall, 1'b0);
        check("t2_wraddr", mem_wraddress, 32'd65);
        next_cycle();
        idle();
        at_neg();
        check("t2_mem65", env_mem[65], 32'hDEADBEEF);
        check("t2_cnt", conflict_cnt, 4'd1);
        next_cycle();

        // Sustained read conflict alternates data, inst, data, ...
        do_reset();
        v_i = n_inst_valid; v_d = n_data_valid;
        inst_rden = 1'b1; inst_rdaddress = 32'd8;
        data_rden = 1'b1; data_rdaddress = 32'd9;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            check("t3_inst_stall", inst_stall, (k % 2) == 0);
            next_cycle();
        end
        idle();
        repeat (2) begin at_neg(); next_cycle(); end
        @(negedge clock);
        check("t3_cnt", conflict_cnt, 4'd6);
        check("t3_inst_valids", n_inst_valid - v_i, 3);
        check("t3_data_valids", n_data_valid - v_d, 3);
        next_cycle();

        // Data-side address wraps modulo 2^W.
        data_rden = 1'b1; data_rdaddress = 32'hFFFF_FFC0;
        at_neg();
        check("t4_wrap", mem_rdaddress, 32'h0);
        next_cycle();
        idle();
        at_neg(); next_cycle();

        // Reset with an inst read in flight.
        do_reset();
        at_neg(); next_cycle();
        inst_rden = 1'b1; inst_rdaddress = 32'd5;
        at_neg();
        reset = 1'b1;
        model_reset();
        data_rden = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_in_reset("t5");
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();
        at_neg();
        check("t5_inst_valid_after", inst_valid, 1'b0);
        check("t5_inst_q_after", inst_q, '0);
        next_cycle();

        // Saturation of the conflict counter.
        do_reset();
        inst_rden = 1'b1; inst_rdaddress = 32'd3;
        data_rden = 1'b1; data_rdaddress = 32'd4;
        repeat (20) begin at_neg(); next_cycle(); end
        idle();
        repeat (2) begin at_neg(); next_cycle(); end
        check("t6_sat", conflict_cnt, 4'd15);
        inst_wren = 1'b1; data_wren = 1'b1;
        repeat (2) begin at_neg(); next_cycle(); end
        idle();
        at_neg();
        check("t6_sat_hold", conflict_cnt, 4'd15);
        next_cycle();

        // Randomised traffic; stalled requests are held stable.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (last_ig) begin
                r = $urandom_range(0, 3);
                inst_rden = r[0]; inst_wren = r[1];
                inst_rdaddress = $urandom_range(0, 79);
                inst_wraddress = $urandom_range(0, 79);
                inst_data = $urandom;
            end
            if (last_dg) begin
                r = $urandom_range(0, 3);
                data_rden = r[0]; data_wren = r[1];
                data_rdaddress = $urandom_range(0, 15);
                data_wraddress = $urandom_range(0, 15);
                data_data = $urandom;
            end
            at_neg();
            next_cycle();
        end
        idle();
        repeat (3) begin at_neg(); next_cycle(); end
        check("inst_queue_drained", inst_exp_q.size(), 0);
        check("data_queue_drained", data_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one dual-port `mem` instance (one read port, one write port, 1-cycle registered read) between the pipeline's instruction and data memory interfaces, so a unified instruction/data memory can replace the separate INST_MEM/DATA_MEM pair. Sits between `pipeline` and `mem`. It grants each port per cycle, stalls the loser on a conflict, relocates data-side addresses by a base offset, and steers returned read data to the requester that issued the read.

## Interface
- WIDTH, 32, data and address width
- DATA_BASE, 64, word offset added to every data-side address
- CNT_W, 16, width of conflict counter
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- inst_data / inst_rdaddress / inst_wraddress  in  WIDTH  instruction-side write data, read address, write address
- inst_rden / inst_wren  in  1  instruction-side read / write request
- inst_q  out  WIDTH  instruction-side read data
- inst_valid  out  1  inst_q holds fresh data this cycle
- inst_stall  out  1  instruction request not accepted this cycle
- data_data / data_rdaddress / data_wraddress  in  WIDTH  data-side equivalents
- data_rden / data_wren  in  1  data-side read / write request
- data_q  out  WIDTH  data-side read data
- data_valid  out  1  data_q holds fresh data this cycle
- data_stall  out  1  data request not accepted this cycle
- mem_data / mem_rdaddress / mem_wraddress  out  WIDTH  to shared mem
- mem_rden / mem_wren  out  1  to shared mem
- mem_q  in  WIDTH  from shared mem
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- Request shape: a port's request is its (rden, wren) pair.
  - The request is active if either bit is set.
  - A request needs the read port if rden=1 and the write port if wren=1.
- Conflict: both ports are active and both need the read port, or both need the write port.
  - No conflict: both requests are granted in the same cycle. Example: inst read plus data write use the two mem ports in parallel.
- Grant is all-or-nothing per port. The loser's stall=1 and none of its signals reach mem.
- Priority register `last_win` (0=inst, 1=data):
  - On a conflict, the port that did not win the previous conflict wins.
  - `last_win` updates only on conflict cycles.
  - Reset value is 0, so data wins the first conflict.
- Mem drive (combinational from requests and `last_win`):
  - mem_rden / mem_rdaddress come from the read-port grantee.
  - mem_wren / mem_wraddress / mem_data come from the write-port grantee.
  - Data-side addresses are presented as address + DATA_BASE, truncated to WIDTH bits (wraps modulo 2^WIDTH).
  - When a port is not granted, its enable=0 and its address/data=0.
- Read tag register `rd_owner` (2 bits: none/inst/data): records which port's read was granted in this cycle.
- Return path, next cycle:
  - The owner's valid=1 and its q=mem_q, passed through combinationally.
  - mem_q is also captured into that port's hold register.
  - Otherwise q shows the hold register and valid=0.
- No forwarding. A same-cycle read and write to the same word returns the read-during-write result of mem (old data).
- conflict_cnt increments by 1 on each conflict cycle and saturates at all-ones.
- Requesters keep their request signals stable while stall=1. The arbiter does not latch requests.
- Reset (asynchronous, may assert mid-operation):
  - `last_win`=0, `rd_owner`=none, hold registers=0, conflict_cnt=0.
  - An in-flight read is discarded: no valid is generated after reset.
  - While reset=1: mem_rden=mem_wren=0, inst_stall=data_stall=1, valids=0, q=0.

## Timing
- Grant and stall are combinational in the request cycle (cycle N).
- A read granted in cycle N has valid and q in cycle N+1. Read latency is 1 cycle, back-to-back reads give 1 word per cycle.
- A write granted in cycle N is committed at the rising edge ending cycle N.
- A stalled port is reconsidered every cycle. Under sustained conflict each port wins every other cycle, so neither port starves for more than 1 cycle.
- A new read may be granted in the same cycle that the previous read's valid is high.

## Test plan
- Memory initialised with mem[5]=0xA5, mem[70]=0x3C; inst reads addr 5 and data reads addr 6 in the same cycle, first after reset.
  - Data wins: mem_rdaddress=70, inst_stall=1, conflict_cnt=1.
  - Next cycle: data_valid=1, data_q=0x3C; inst granted, mem_rdaddress=5.
  - Cycle after: inst_valid=1, inst_q=0xA5.
- Inst reads addr 0 while data writes 0xDEADBEEF to addr 1, same cycle.
  - Both granted, no stall, conflict_cnt unchanged.
  - mem[65]=0xDEADBEEF after the edge.
- Both ports hold a read request for 6 cycles.
  - Grants alternate data, inst, data, inst, data, inst.
  - Each port gets 3 valids; conflict_cnt=6.
- data_rdaddress=0xFFFFFFC0 with DATA_BASE=64.
  - mem_rdaddress=0x00000000 (wrap).
- Assert reset one cycle after an inst read is granted.
  - inst_valid stays 0, inst_q=0, conflict_cnt=0.
  - Both stalls are 1 until reset deasserts.
- With CNT_W=4, force 20 conflict cycles.
  - conflict_cnt=15 and holds at 15.
